// File: rtl/dcfifo_rdctrl.sv
// Read-side pointer and status controller of the dual-clock FIFO.
// Consumes the synchronized gray write pointer and keeps the read pointer, RAM read port and status registered.
module dcfifo_rdctrl #(
   parameter int    lpm_widthu         = 4,
   parameter string underflow_checking = "ON"
) (
   input  logic                  clock,
   input  logic                  aclr,
   input  logic                  rdreq,
   input  logic [lpm_widthu:0]   ws_wrptr_g,
   output logic [lpm_widthu-1:0] rdaddr,
   output logic                  rden,
   output logic [lpm_widthu:0]   rdptr_g,
   output logic                  rdempty,
   output logic                  rdfull,
   output logic [lpm_widthu-1:0] rdusedw,
   output logic                  rd_underflow
);

   localparam int PW       = lpm_widthu + 1;
   localparam bit CHECK_ON = (underflow_checking == "ON");

   logic [PW-1:0] rdptr_b;
   logic [PW-1:0] rdptr_nx;
   logic [PW-1:0] wrptr_b;
   logic [PW-1:0] diff;
   logic          acc;

   // rdreq is a request; rden marks the cycle it is accepted, and the pointer moves on that same edge.
   always_comb begin
      acc = rdreq;
      if (CHECK_ON) acc = rdreq & ~rdempty;
   end

   assign rden     = acc;
   assign rdptr_nx = rdptr_b + PW'(acc);

   always_comb begin
      wrptr_b = '0;
      for (int i = 0; i < PW; i++) wrptr_b[i] = ^(ws_wrptr_g >> i);
   end

   // Status uses the post-edge read pointer so flags never lag a local read.
   assign diff = wrptr_b - rdptr_nx;

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         rdptr_b      <= '0;
         rdptr_g      <= '0;
         rdaddr       <= '0;
         rdempty      <= 1'b1;
         rdfull       <= 1'b0;
         rdusedw      <= '0;
         rd_underflow <= 1'b0;
      end else begin
         rdptr_b      <= rdptr_nx;
         rdptr_g      <= rdptr_nx ^ (rdptr_nx >> 1);
         rdaddr       <= rdptr_nx[lpm_widthu-1:0];
         rdempty      <= (diff == '0);
         rdfull       <= diff[lpm_widthu];
         rdusedw      <= diff[lpm_widthu-1:0];
         rd_underflow <= rdreq & rdempty;
      end
   end

endmodule

// File: tb/tb_dcfifo_rdctrl.sv
// Directed self-checking bench for dcfifo_rdctrl (checking ON and OFF instances).
module tb_dcfifo_rdctrl;

   localparam int W = 4;

   logic         clock;
   logic         aclr;
   logic         rdreq, rdreq_off;
   logic [W:0]   ws_wrptr_g, ws_off;
   logic [W-1:0] rdaddr, rdaddr_off;
   logic         rden, rden_off;
   logic [W:0]   rdptr_g, rdptr_g_off;
   logic         rdempty, rdempty_off;
   logic         rdfull, rdfull_off;
   logic [W-1:0] rdusedw, rdusedw_off;
   logic         rd_underflow, rd_underflow_off;

   int n_checks = 0;
   int n_pass   = 0;
   logic [W-1:0] exp_q[$];

   dcfifo_rdctrl #(.lpm_widthu(W), .underflow_checking("ON")) dut (
      .clock(clock), .aclr(aclr), .rdreq(rdreq), .ws_wrptr_g(ws_wrptr_g),
      .rdaddr(rdaddr), .rden(rden), .rdptr_g(rdptr_g), .rdempty(rdempty),
      .rdfull(rdfull), .rdusedw(rdusedw), .rd_underflow(rd_underflow)
   );

   dcfifo_rdctrl #(.lpm_widthu(W), .underflow_checking("OFF")) dut_off (
      .clock(clock), .aclr(aclr), .rdreq(rdreq_off), .ws_wrptr_g(ws_off),
      .rdaddr(rdaddr_off), .rden(rden_off), .rdptr_g(rdptr_g_off), .rdempty(rdempty_off),
      .rdfull(rdfull_off), .rdusedw(rdusedw_off), .rd_underflow(rd_underflow_off)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [W:0] gray(input logic [W:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [W:0] rd_m, wr_m, prev_g, d;
      aclr = 1'b1; rdreq = 1'b0; rdreq_off = 1'b0; ws_wrptr_g = '0; ws_off = '0;
      #2;
      check("rst_empty",  32'(rdempty), 32'd1);
      check("rst_full",   32'(rdfull), 32'd0);
      check("rst_usedw",  32'(rdusedw), 32'd0);
      check("rst_ptr_g",  32'(rdptr_g), 32'd0);
      check("rst_uflow",  32'(rd_underflow), 32'd0);
      check("rst_rden",   32'(rden), 32'd0);
      @(negedge clock);
      aclr = 1'b0;
      step();
      check("idle_empty", 32'(rdempty), 32'd1);

      // fill: write pointer 1,2,3 in gray
      for (int i = 1; i <= 3; i++) begin
         ws_wrptr_g = gray(5'(i));
         step();
         check("fill_usedw", 32'(rdusedw), 32'(i));
         check("fill_empty", 32'(rdempty), 32'd0);
      end

      // drain three entries, then one over-read
      exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
      rdreq = 1'b1;
      #1 check("drain_rden", 32'(rden), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("drain_addr", 32'(rdaddr), 32'(exp_q.pop_front()));
         check("drain_usedw", 32'(rdusedw), 32'(2 - i));
      end
      check("drain_empty", 32'(rdempty), 32'd1);
      check("over_rden", 32'(rden), 32'd0);
      step();
      check("over_uflow", 32'(rd_underflow), 32'd1);
      check("over_ptr_g", 32'(rdptr_g), 32'd2);
      check("over_addr",  32'(rdaddr), 32'd3);
      rdreq = 1'b0;
      step();
      check("uflow_pulse", 32'(rd_underflow), 32'd0);

      // mid-cycle asynchronous reset with a read in flight
      ws_wrptr_g = gray(5'd5);
      step();
      check("pre_usedw", 32'(rdusedw), 32'd2);
      rdreq = 1'b1;
      #1 check("pre_rden", 32'(rden), 32'd1);
      aclr = 1'b1;
      #1;
      check("arst_empty", 32'(rdempty), 32'd1);
      check("arst_rden",  32'(rden), 32'd0);
      check("arst_ptr_g", 32'(rdptr_g), 32'd0);
      check("arst_addr",  32'(rdaddr), 32'd0);
      check("arst_usedw", 32'(rdusedw), 32'd0);
      rdreq = 1'b0; ws_wrptr_g = '0;
      #1 aclr = 1'b0;
      step();
      check("rel_empty", 32'(rdempty), 32'd1);

      // full: write pointer 16 ahead
      ws_wrptr_g = 5'b11000;
      step();
      check("full_flag",  32'(rdfull), 32'd1);
      check("full_usedw", 32'(rdusedw), 32'd0);
      check("full_empty", 32'(rdempty), 32'd0);
      rdreq = 1'b1;
      step();
      rdreq = 1'b0;
      check("unfull_flag",  32'(rdfull), 32'd0);
      check("unfull_usedw", 32'(rdusedw), 32'd15);

      // occupancy 2, then simultaneous write+read through pointer wrap
      rd_m = 5'd1; wr_m = 5'd3;
      ws_wrptr_g = gray(wr_m);
      step();
      check("occ2_usedw", 32'(rdusedw), 32'd2);
      prev_g = rdptr_g;
      rdreq = 1'b1;
      for (int i = 0; i < 40; i++) begin
         wr_m = wr_m + 5'd1;
         rd_m = rd_m + 5'd1;
         ws_wrptr_g = gray(wr_m);
         step();
         d = rdptr_g ^ prev_g;
         check("wrap_usedw", 32'(rdusedw), 32'd2);
         check("wrap_ptr_g", 32'(rdptr_g), 32'(gray(rd_m)));
         check("wrap_onebit", 32'($countones(d)), 32'd1);
         prev_g = rdptr_g;
      end
      rdreq = 1'b0;

      // checking OFF: read while empty still advances
      rdreq_off = 1'b1;
      #1 check("off_rden", 32'(rden_off), 32'd1);
      step();
      rdreq_off = 1'b0;
      check("off_ptr_g", 32'(rdptr_g_off), 32'd1);
      check("off_addr",  32'(rdaddr_off), 32'd1);
      check("off_uflow", 32'(rd_underflow_off), 32'd1);
      check("off_full",  32'(rdfull_off), 32'd1);
      check("off_usedw", 32'(rdusedw_off), 32'd15);
      check("off_empty", 32'(rdempty_off), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
